bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//  Parallel-to-serial front end for the bit-stream pattern detectors (e.g. the 1100 Moore detector).
//  - Accepts WIDTH-bit words on a valid/ready handshake.
//  - Emits one bit per clock on sout/sout_valid, with one-word buffering so consecutive words stream gap-free.
//  - The downstream detector samples sout every cycle while sout_valid=1. There is no downstream backpressure.
// PARAMETERS
//  WIDTH      8   data word width in bits (legal range 2..32)
//  MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      reset: asynchronous, active-high
//  flush       in   1      synchronous clear of all buffered and in-flight data
//  din         in   WIDTH  parallel word
//  din_valid   in   1      din is valid
//  din_ready   out  1      word is accepted on an edge where din_valid & din_ready
//  sout        out  1      serial bit, registered
//  sout_valid  out  1      sout carries a data bit this cycle
//  last        out  1      final bit of the current word, qualified by sout_valid
//  busy        out  1      shifter or hold buffer is occupied
// BEHAVIOUR
//  - Reset:
//      state=IDLE, hold_full=0, bit count=0.
//      sout=0, sout_valid=0, last=0, busy=0.
//      din_ready=0 while rst is high.
//  - din_ready = ~hold_full & ~flush & ~rst. It is combinational from registered state only; din_valid does not feed it.
//  - States:
//      IDLE: sout_valid=0, sout=0.
//      SHIFT: one bit is emitted per cycle; cnt runs 0..NBITS-1. NBITS=WIDTH, or WIDTH+1 when PARITY_EN is defined.
//  - Latency: a word accepted on edge k has its first bit on sout in the cycle after edge k, and its final bit in cycle k+NBITS.
//  - Acceptance in IDLE: the word loads directly into the shifter and state goes to SHIFT.
//  - Acceptance in SHIFT with cnt<NBITS-1: the word goes to the hold buffer; hold_full=1.
//  - Acceptance in SHIFT with cnt==NBITS-1 and hold empty: the word bypasses hold and loads into the shifter. cnt=0, and there is no gap.
//  - End of word (edge ending the cnt==NBITS-1 cycle), in priority order:
//      1. hold_full: load hold into the shifter, hold_full=0, cnt=0, stay in SHIFT.
//      2. else, a word is accepted: bypass load as above.
//      3. else: go to IDLE, sout_valid=0 in the next cycle.
//  - last=1 exactly when sout_valid=1 and cnt==NBITS-1.
//  - busy = (state==SHIFT) | hold_full.
//  - Flush:
//      flush=1 at an edge forces IDLE, hold_full=0 and cnt=0, and discards any concurrent input word (din_ready is already 0).
//      Flush has priority over every other event.
//  - Reset asserted mid-word clears the outputs immediately (async). The partial word is lost. After release, the block restarts in IDLE.
//  - sout is driven 0 whenever sout_valid=0.
// CONFIGURATION
//  PARITY_EN (defined):
//    - After the WIDTH data bits, one extra bit is emitted: even parity (XOR of all data bits of that word).
//    - last is asserted on the parity bit; NBITS=WIDTH+1.
//    - The parity bit is computed at load time from the loaded word.
//  PARITY_EN (undefined): NBITS=WIDTH, no parity logic, last is asserted on data bit 0 (MSB_FIRST=1) or on bit WIDTH-1 (MSB_FIRST=0).
// TESTING
//  1. Single word, WIDTH=8, MSB_FIRST=1, din=8'hCC accepted at edge 0
//       -> sout=1,1,0,0,1,1,0,0 in cycles 1..8, last only in cycle 8, sout_valid=0 in cycle 9, busy=0 in cycle 9.
//  2. MSB_FIRST=0, din=8'h03
//       -> sout=1,1,0,0,0,0,0,0, last in cycle 8.
//  3. Back-to-back 8'hF0 then 8'h0F with din_valid held
//       -> 16 contiguous valid bits 1111000000001111, no gap.
//       -> din_ready=0 while hold is full; it returns to 1 on the edge where hold loads into the shifter.
//  4. Three words presented continuously (A5,5A,FF)
//       -> third word is held off (din_ready=0) until word 1 finishes.
//       -> 24 contiguous bits, last in cycles 8, 16 and 24.
//  5. flush=1 for one cycle after 3 bits of 8'hAA, with hold full
//       -> next cycle sout_valid=0, busy=0, din_ready=1, and no further bits from either word.
//  6. Async rst pulse mid-word
//       -> sout, sout_valid, last and busy go to 0 within the same cycle; a new word after release serializes correctly.
//       -> With PARITY_EN: din=8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1, last on the 9th bit.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in on valid/ready, one bit per clock out,
// with a one-word hold buffer for gap-free streaming. Optional macro PARITY_EN appends an even-parity bit.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

`ifdef PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [NBITS-1:0]   shift_r, shift_s;
  logic [WIDTH-1:0]   hold_r, hold_s;
  logic               hold_full_r, hold_full_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic               sout_r, sout_s;
  logic               accept_s;
  logic               do_load_s;
  logic [WIDTH-1:0]   load_word_s;
  logic [NBITS-1:0]   load_frame_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // Frame bit NBITS-1 is transmitted first; the parity bit, when present, goes out last.
  function automatic logic [NBITS-1:0] frame(input logic [WIDTH-1:0] w);
    logic [NBITS-1:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f[NBITS-1-i] = MSB_FIRST ? w[WIDTH-1-i] : w[i];
    end
`ifdef PARITY_EN
    f[0] = even_parity(w);
`endif
    return f;
  endfunction

  assign din_ready  = ~hold_full_r & ~flush & ~rst;
  assign accept_s   = din_valid & din_ready;
  assign sout       = sout_r;
  assign sout_valid = (state_r == SHIFT);
  assign last       = (state_r == SHIFT) & (cnt_r == CNT_LAST);
  assign busy       = (state_r == SHIFT) | hold_full_r;

  // Next-state, shifter, hold-buffer and serial-bit logic
  always_comb begin
    state_s      = state_r;
    shift_s      = shift_r;
    hold_s       = hold_r;
    hold_full_s  = hold_full_r;
    cnt_s        = cnt_r;
    sout_s       = 1'b0;
    do_load_s    = 1'b0;
    load_word_s  = din;
    if (flush) begin
      state_s     = IDLE;
      hold_full_s = 1'b0;
      cnt_s       = '0;
    end else if (state_r == IDLE) begin
      if (accept_s) begin
        do_load_s = 1'b1;
      end else begin
        cnt_s = '0;
      end
    end else if (cnt_r == CNT_LAST) begin
      // End of word: a held word wins over a bypass, otherwise drop back to idle.
      cnt_s = '0;
      if (hold_full_r) begin
        do_load_s   = 1'b1;
        load_word_s = hold_r;
        hold_full_s = 1'b0;
      end else if (accept_s) begin
        do_load_s = 1'b1;
      end else begin
        state_s = IDLE;
      end
    end else begin
      cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      sout_s  = shift_r[NBITS-1];
      shift_s = {shift_r[NBITS-2:0], 1'b0};
      if (accept_s) begin
        hold_s      = din;
        hold_full_s = 1'b1;
      end else begin
        hold_s = hold_r;
      end
    end
    load_frame_s = frame(load_word_s);
    if (do_load_s) begin
      state_s = SHIFT;
      cnt_s   = '0;
      sout_s  = load_frame_s[NBITS-1];
      shift_s = {load_frame_s[NBITS-2:0], 1'b0};
    end else begin
      shift_s = shift_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      shift_r     <= '0;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      cnt_r       <= '0;
      sout_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      cnt_r       <= cnt_s;
      sout_r      <= sout_s;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: MSB-first and LSB-first instances against a queue-based model.
module tb_bit_serializer;
  localparam int W = 8;
`ifdef PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic rdy_m, sout_m, val_m, last_m, busy_m;
  logic rdy_l, sout_l, val_l, last_l, busy_l;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  // Pending serial bits per instance: bit0 = data bit, bit1 = last flag; front = bit on sout now.
  int qm[$];
  int ql[$];
  bit cap_m[$];
  bit cap_l[$];
  bit caplast_m[$];
  int capcyc[$];
  bit model_acc;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .sout(sout_m), .sout_valid(val_m), .last(last_m), .busy(busy_m));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .sout(sout_l), .sout_valid(val_l), .last(last_l), .busy(busy_l));

  function automatic bit emit_bit(input logic [7:0] w, input bit msb, input int i);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  // Model: a word is taken when no more than one word's worth of bits is still pending.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qm.delete();
      ql.delete();
    end else begin
      model_acc = din_valid && !flush && (qm.size() <= NB);
      if (flush) begin
        qm.delete();
        ql.delete();
      end else begin
        if (qm.size() > 0) begin
          void'(qm.pop_front());
          void'(ql.pop_front());
        end
        if (model_acc) begin
          for (int i = 0; i < NB; i++) begin
            qm.push_back(int'(emit_bit(din, 1'b1, i)) | ((i == NB-1) ? 2 : 0));
            ql.push_back(int'(emit_bit(din, 1'b0, i)) | ((i == NB-1) ? 2 : 0));
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc_n);
    end
  endtask

  task automatic compare_loop();
    int ev, el, bm, bl, er;
    forever begin
      @(negedge clk);
      cyc_n++;
      ev = (qm.size() > 0) ? 1 : 0;
      bm = ev ? (qm[0] & 1) : 0;
      bl = ev ? (ql[0] & 1) : 0;
      el = ev ? ((qm[0] >> 1) & 1) : 0;
      er = (!rst && !flush && qm.size() <= NB) ? 1 : 0;
      chk("m_valid", {31'd0, val_m}, ev);
      chk("m_sout",  {31'd0, sout_m}, bm);
      chk("m_last",  {31'd0, last_m}, el);
      chk("m_busy",  {31'd0, busy_m}, ev);
      chk("m_ready", {31'd0, rdy_m}, er);
      chk("l_valid", {31'd0, val_l}, ev);
      chk("l_sout",  {31'd0, sout_l}, bl);
      chk("l_last",  {31'd0, last_l}, el);
      chk("l_ready", {31'd0, rdy_l}, er);
      if (val_m === 1'b1) begin
        cap_m.push_back(sout_m);
        cap_l.push_back(sout_l);
        caplast_m.push_back(last_m);
        capcyc.push_back(cyc_n);
      end
    end
  endtask

  function automatic logic [31:0] bits_of(input int start, input int n, input bit lsb);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++)
      if (start + i < cap_m.size()) v = {v[30:0], lsb ? cap_l[start+i] : cap_m[start+i]};
    return v;
  endfunction

  function automatic logic [31:0] last_mask(input int start, input int n);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++)
      if (start + i < caplast_m.size() && caplast_m[start+i]) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int span(input int start, input int n);
    if (start + n - 1 >= capcyc.size()) return -1;
    return capcyc[start+n-1] - capcyc[start];
  endfunction

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [7:0] w);
    int t = 0;
    din = w;
    din_valid = 1'b1;
    #1;
    while (rdy_m !== 1'b1 && t < 100) begin
      cyc();
      #1;
      t++;
    end
    chk("send_timeout", {31'd0, (t < 100)}, 32'd1);
    cyc();
    din_valid = 1'b0;
  endtask

  int s, s2;

  initial begin
    fork
      compare_loop();
    join_none
    cyc();
    cyc();
    chk("reset_valid", {31'd0, val_m}, 32'd0);
    chk("reset_busy",  {31'd0, busy_m}, 32'd0);
    chk("reset_ready", {31'd0, rdy_m}, 32'd0);
    chk("reset_sout",  {31'd0, sout_m}, 32'd0);
    rst = 1'b0;
    cyc();

    // Single word CC
    s = cap_m.size();
    send(8'hCC);
    idle(10);
    chk("t1_count", cap_m.size() - s, NB);
    chk("t1_idle_valid", {31'd0, val_m}, 32'd0);
    chk("t1_idle_busy",  {31'd0, busy_m}, 32'd0);
`ifndef PARITY_EN
    chk("t1_msb_bits", bits_of(s, 8, 1'b0), 32'hCC);
    chk("t1_lsb_bits", bits_of(s, 8, 1'b1), 32'h33);
    chk("t1_last_pos", last_mask(s, 8), 32'h80);
`endif

    // LSB-first word 03
    s = cap_m.size();
    send(8'h03);
    idle(10);
    chk("t2_count", cap_m.size() - s, NB);
`ifndef PARITY_EN
    chk("t2_lsb_bits", bits_of(s, 8, 1'b1), 32'hC0);
    chk("t2_msb_bits", bits_of(s, 8, 1'b0), 32'h03);
`endif

    // Back-to-back F0, 0F
    s = cap_m.size();
    send(8'hF0);
    send(8'h0F);
    idle(20);
    chk("t3_count", cap_m.size() - s, 2 * NB);
    chk("t3_gapless", span(s, 2 * NB), 2 * NB - 1);
`ifndef PARITY_EN
    chk("t3_bits", bits_of(s, 16, 1'b0), 32'hF00F);
`endif

    // Three words, third held off
    s = cap_m.size();
    send(8'hA5);
    send(8'h5A);
    send(8'hFF);
    idle(30);
    chk("t4_count", cap_m.size() - s, 3 * NB);
    chk("t4_gapless", span(s, 3 * NB), 3 * NB - 1);
`ifndef PARITY_EN
    chk("t4_bits", bits_of(s, 24, 1'b0), 32'hA55AFF);
    chk("t4_last_pos", last_mask(s, 24), 32'h808080);
`endif

    // Flush after 3 bits with hold full; a concurrent word is discarded
    s = cap_m.size();
    send(8'hAA);
    send(8'h55);
    cyc();
    flush = 1'b1;
    din = 8'h77;
    din_valid = 1'b1;
    cyc();
    flush = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("t5_valid", {31'd0, val_m}, 32'd0);
    chk("t5_busy",  {31'd0, busy_m}, 32'd0);
    chk("t5_ready", {31'd0, rdy_m}, 32'd1);
    idle(12);
    chk("t5_count", cap_m.size() - s, 3);
    chk("t5_bits_m", bits_of(s, 3, 1'b0), 32'h5);
    chk("t5_bits_l", bits_of(s, 3, 1'b1), 32'h2);

    // Async reset mid-word, then a fresh word
    s = cap_m.size();
    send(8'h3C);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("t6_sout",  {31'd0, sout_m}, 32'd0);
    chk("t6_valid", {31'd0, val_m}, 32'd0);
    chk("t6_last",  {31'd0, last_m}, 32'd0);
    chk("t6_busy",  {30'd0, busy_m, busy_l}, 32'd0);
    chk("t6_valid_l", {31'd0, val_l}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    s2 = cap_m.size();
    chk("t6_partial", s2 - s, 3);
    send(8'h07);
    idle(12);
    chk("t6_count", cap_m.size() - s2, NB);
`ifdef PARITY_EN
    chk("t6_parity_bits", bits_of(s2, 9, 1'b0), 32'h00F);
    chk("t6_parity_last", last_mask(s2, 9), 32'h100);
`else
    chk("t6_bits_m", bits_of(s2, 8, 1'b0), 32'h07);
    chk("t6_bits_l", bits_of(s2, 8, 1'b1), 32'hE0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
